// File: rtl/shreg_pkg.sv
// Shared mode encoding for universal_shift_register and its word counter.
package shreg_pkg;

  typedef logic [2:0] shreg_mode_t;

  localparam shreg_mode_t MODE_HOLD = 3'b000;
  localparam shreg_mode_t MODE_SHL  = 3'b001;
  localparam shreg_mode_t MODE_SHR  = 3'b010;
  localparam shreg_mode_t MODE_LOAD = 3'b011;
  localparam shreg_mode_t MODE_ROTL = 3'b100;
  localparam shreg_mode_t MODE_ROTR = 3'b101;
  localparam shreg_mode_t MODE_CLR  = 3'b110;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shift operations modulo WIDTH and emits a registered one-cycle
// word_done pulse on the cycle after each wrap.
module shift_word_counter
  import shreg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          word_done_d, word_done_q;

  // Wrap is compared against WIDTH-1 explicitly so non-power-of-2 widths work.
  always_comb begin
    cnt_d       = cnt_q;
    word_done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign word_done = word_done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Bidirectional shift register with parallel load, clear and word counter.
// Rotate modes are compiled in only when USR_ROTATE_EN is defined.
module universal_shift_register
  import shreg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic [2:0]       mode,
  input  logic             SI_L,
  input  logic             SI_R,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] PO,
  output logic             SO_L,
  output logic             SO_R,
  output logic             word_done
);

  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             inc, clr;
  shreg_mode_t      mode_s;

  assign mode_s = mode;

  // Reserved code and (without rotate) the rotate codes fall into default: hold.
  always_comb begin
    shreg_d = shreg_q;
    inc     = 1'b0;
    clr     = 1'b0;
    if (clken) begin
      case (mode_s)
        MODE_SHL: begin
          shreg_d = {shreg_q[WIDTH-2:0], SI_L};
          inc     = 1'b1;
        end
        MODE_SHR: begin
          shreg_d = {SI_R, shreg_q[WIDTH-1:1]};
          inc     = 1'b1;
        end
        MODE_LOAD: begin
          shreg_d = PI;
          clr     = 1'b1;
        end
`ifdef USR_ROTATE_EN
        MODE_ROTL: begin
          shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          inc     = 1'b1;
        end
        MODE_ROTR: begin
          shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
          inc     = 1'b1;
        end
`endif
        MODE_CLR: begin
          shreg_d = RESET_VAL;
          clr     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= RESET_VAL;
    else     shreg_q <= shreg_d;
  end

  assign PO   = shreg_q;
  assign SO_L = shreg_q[WIDTH-1];
  assign SO_R = shreg_q[0];

  shift_word_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .clr       (clr),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at WIDTH 8 (RESET_VAL A5), 5 and 32.
module tb_universal_shift_register;
  import shreg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // WIDTH=8, RESET_VAL=A5
  logic       c8_clken = 1'b0;
  logic [2:0] c8_mode = 3'b000;
  logic       c8_sil = 1'b0, c8_sir = 1'b0;
  logic [7:0] c8_pi = 8'h00;
  logic [7:0] c8_po;
  logic       c8_sol, c8_sor, c8_wd;

  // WIDTH=5, default RESET_VAL
  logic       c5_clken = 1'b0;
  logic [2:0] c5_mode = 3'b000;
  logic       c5_sil = 1'b0;
  logic [4:0] c5_po;
  logic       c5_sol, c5_sor, c5_wd;

  // WIDTH=32, default RESET_VAL
  logic        c32_clken = 1'b0;
  logic [2:0]  c32_mode = 3'b000;
  logic        c32_sil = 1'b0;
  logic [31:0] c32_po;
  logic        c32_sol, c32_sor, c32_wd;

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
    .clk(clk), .rst(rst), .clken(c8_clken), .mode(c8_mode), .SI_L(c8_sil), .SI_R(c8_sir),
    .PI(c8_pi), .PO(c8_po), .SO_L(c8_sol), .SO_R(c8_sor), .word_done(c8_wd));

  universal_shift_register #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .clken(c5_clken), .mode(c5_mode), .SI_L(c5_sil), .SI_R(1'b0),
    .PI(5'h00), .PO(c5_po), .SO_L(c5_sol), .SO_R(c5_sor), .word_done(c5_wd));

  universal_shift_register #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .clken(c32_clken), .mode(c32_mode), .SI_L(c32_sil), .SI_R(1'b0),
    .PI(32'h0), .PO(c32_po), .SO_L(c32_sol), .SO_R(c32_sor), .word_done(c32_wd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [2:0] m, input logic sl, input logic sr, input logic [7:0] p);
    c8_clken = 1'b1; c8_mode = m; c8_sil = sl; c8_sir = sr; c8_pi = p;
    tick();
    c8_clken = 1'b0; c8_mode = MODE_HOLD;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (c8_po !== 8'hA5) begin errors++; $display("FAIL reset_po got=%h exp=a5", c8_po); end
    checks++; if (c8_sol !== 1'b1) begin errors++; $display("FAIL reset_sol got=%b exp=1", c8_sol); end
    checks++; if (c8_sor !== 1'b1) begin errors++; $display("FAIL reset_sor got=%b exp=1", c8_sor); end
    checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL reset_wd got=%b exp=0", c8_wd); end
    checks++; if (c5_po !== 5'h00) begin errors++; $display("FAIL reset_po5 got=%h exp=00", c5_po); end
    checks++; if (c32_po !== 32'h0) begin errors++; $display("FAIL reset_po32 got=%h exp=0", c32_po); end
    op8(MODE_LOAD, 1'b0, 1'b0, 8'h00);
    checks++; if (c8_po !== 8'h00) begin errors++; $display("FAIL load00 got=%h exp=00", c8_po); end
    op8(MODE_CLR, 1'b0, 1'b0, 8'hFF);
    checks++; if (c8_po !== 8'hA5) begin errors++; $display("FAIL clr_po got=%h exp=a5", c8_po); end
    checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL clr_wd got=%b exp=0", c8_wd); end
  endtask

  task automatic test_sipo();
    logic [7:0] bits;
    bits = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      op8(MODE_SHL, bits[7-i], 1'b0, 8'h00);
      checks++;
      if (c8_wd !== (i == 7)) begin errors++; $display("FAIL sipo_wd shift=%0d got=%b exp=%b", i + 1, c8_wd, (i == 7)); end
    end
    checks++; if (c8_po !== 8'hB2) begin errors++; $display("FAIL sipo_po got=%h exp=b2", c8_po); end
    op8(MODE_SHL, 1'b0, 1'b0, 8'h00);
    checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL sipo_9th_wd got=%b exp=0", c8_wd); end
    checks++; if (c8_po !== 8'h64) begin errors++; $display("FAIL sipo_9th_po got=%h exp=64", c8_po); end
  endtask

  task automatic test_piso();
    logic [7:0] src;
    src = 8'h81;
    op8(MODE_LOAD, 1'b0, 1'b0, 8'h81);
    checks++; if (c8_sor !== 1'b1) begin errors++; $display("FAIL piso_sor0 got=%b exp=1", c8_sor); end
    checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL piso_load_wd got=%b exp=0", c8_wd); end
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        for (int d = 0; d < 3; d++) begin
          c8_mode = MODE_SHR; c8_clken = 1'b0;
          tick();
          checks++; if (c8_po !== 8'h08) begin errors++; $display("FAIL piso_frozen_po got=%h exp=08", c8_po); end
          checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL piso_frozen_wd got=%b exp=0", c8_wd); end
        end
      end
      op8(MODE_SHR, 1'b0, 1'b0, 8'h00);
      checks++;
      if (c8_wd !== (k == 8)) begin errors++; $display("FAIL piso_wd shift=%0d got=%b exp=%b", k, c8_wd, (k == 8)); end
      if (k < 8) begin
        checks++;
        if (c8_sor !== src[k]) begin errors++; $display("FAIL piso_sor shift=%0d got=%b exp=%b", k, c8_sor, src[k]); end
      end
    end
    checks++; if (c8_po !== 8'h00) begin errors++; $display("FAIL piso_final_po got=%h exp=00", c8_po); end
  endtask

  task automatic test_counter_clear();
    for (int i = 0; i < 5; i++) op8(MODE_SHL, 1'b0, 1'b0, 8'h00);
    op8(MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL cclr_load_wd got=%b exp=0", c8_wd); end
    for (int i = 0; i < 8; i++) begin
      op8(MODE_SHL, 1'b0, 1'b0, 8'h00);
      checks++;
      if (c8_wd !== (i == 7)) begin errors++; $display("FAIL cclr_wd shift=%0d got=%b exp=%b", i + 1, c8_wd, (i == 7)); end
    end
    for (int i = 0; i < 5; i++) op8(MODE_SHL, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (c8_po !== 8'hA5) begin errors++; $display("FAIL midrst_po got=%h exp=a5", c8_po); end
    for (int i = 0; i < 7; i++) begin
      op8(MODE_SHL, 1'b0, 1'b0, 8'h00);
      checks++;
      if (c8_wd !== 1'b0) begin errors++; $display("FAIL midrst_wd shift=%0d got=%b exp=0", i + 1, c8_wd); end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_l [3];
    logic [7:0] exp_r [4];
`ifdef USR_ROTATE_EN
    exp_l = '{8'h02, 8'h04, 8'h08};
    exp_r = '{8'h04, 8'h02, 8'h01, 8'h80};
`else
    exp_l = '{8'h01, 8'h01, 8'h01};
    exp_r = '{8'h01, 8'h01, 8'h01, 8'h01};
`endif
    op8(MODE_LOAD, 1'b0, 1'b0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      op8(MODE_ROTL, 1'b1, 1'b1, 8'h00);
      checks++; if (c8_po !== exp_l[i]) begin errors++; $display("FAIL rotl_po n=%0d got=%h exp=%h", i + 1, c8_po, exp_l[i]); end
      checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL rotl_wd n=%0d got=%b exp=0", i + 1, c8_wd); end
    end
    for (int i = 0; i < 4; i++) begin
      op8(MODE_ROTR, 1'b1, 1'b1, 8'h00);
      checks++; if (c8_po !== exp_r[i]) begin errors++; $display("FAIL rotr_po n=%0d got=%h exp=%h", i + 1, c8_po, exp_r[i]); end
      checks++; if (c8_wd !== 1'b0) begin errors++; $display("FAIL rotr_wd n=%0d got=%b exp=0", i + 1, c8_wd); end
    end
    op8(3'b111, 1'b1, 1'b1, 8'hFF);
    checks++; if (c8_po !== exp_r[3]) begin errors++; $display("FAIL reserved_po got=%h exp=%h", c8_po, exp_r[3]); end
  endtask

  task automatic test_width5();
    for (int i = 0; i < 10; i++) begin
      c5_clken = 1'b1; c5_mode = MODE_SHL; c5_sil = 1'b1;
      tick();
      checks++;
      if (c5_wd !== (i == 4 || i == 9)) begin
        errors++; $display("FAIL w5_wd shift=%0d got=%b exp=%b", i + 1, c5_wd, (i == 4 || i == 9));
      end
    end
    c5_clken = 1'b0; c5_mode = MODE_HOLD;
    tick();
    checks++; if (c5_wd !== 1'b0) begin errors++; $display("FAIL w5_idle_wd got=%b exp=0", c5_wd); end
    checks++; if (c5_po !== 5'h1F) begin errors++; $display("FAIL w5_po got=%h exp=1f", c5_po); end
  endtask

  task automatic test_back_to_back_w32();
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      c32_clken = 1'b1; c32_mode = MODE_SHL; c32_sil = pat[31-i];
      tick();
      checks++;
      if (c32_wd !== (i == 31)) begin errors++; $display("FAIL w32_load_wd shift=%0d got=%b exp=%b", i + 1, c32_wd, (i == 31)); end
    end
    checks++; if (c32_po !== 32'hDEADBEEF) begin errors++; $display("FAIL w32_po got=%h exp=deadbeef", c32_po); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (c32_sol !== pat[31-k]) begin errors++; $display("FAIL w32_sol bit=%0d got=%b exp=%b", 31 - k, c32_sol, pat[31-k]); end
      c32_clken = 1'b1; c32_mode = MODE_SHL; c32_sil = 1'b0;
      tick();
      checks++;
      if (c32_wd !== (k == 31)) begin errors++; $display("FAIL w32_replay_wd shift=%0d got=%b exp=%b", k + 33, c32_wd, (k == 31)); end
    end
    c32_clken = 1'b0; c32_mode = MODE_HOLD;
    checks++; if (c32_po !== 32'h0) begin errors++; $display("FAIL w32_final_po got=%h exp=0", c32_po); end
  endtask

  initial begin
    test_reset();
    test_sipo();
    test_piso();
    test_counter_clear();
    test_rotate();
    test_width5();
    test_back_to_back_w32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's 32-bit SISO shift register. Adds bidirectional shift, parallel load/readout, clear and optional rotate, plus a shift counter that flags each completed WIDTH-bit word. Used as a SIPO/PISO converter and general data-path shifter between serial links and parallel registers.

Parameters:
WIDTH, 32, register width in bits; legal range is 2 or more.
RESET_VAL, {WIDTH{1'b0}}, register contents after reset and after a clear.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
clken  input  1  active-high clock enable; qualifies every mode
mode  input  3  operation select (encoding below)
SI_L  input  1  serial in at the LSB end, used by shift-left
SI_R  input  1  serial in at the MSB end, used by shift-right
PI  input  WIDTH  parallel load data
PO  output  WIDTH  parallel out; direct view of the register
SO_L  output  1  serial out, MSB; equals shreg[WIDTH-1]
SO_R  output  1  serial out, LSB; equals shreg[0]
word_done  output  1  one-cycle pulse when the shift counter wraps

Behaviour:
- Clocking and reset: single clock, synchronous active-high reset; rst has priority over clken and mode.
- Reset values: shreg=RESET_VAL, so PO=RESET_VAL, SO_L=RESET_VAL[WIDTH-1], SO_R=RESET_VAL[0]; cnt=0; word_done=0.
- Mode encoding, applied only when clken=1:
  - 000 HOLD: no change.
  - 001 SHL: shreg <= {shreg[WIDTH-2:0], SI_L}.
  - 010 SHR: shreg <= {SI_R, shreg[WIDTH-1:1]}.
  - 011 LOAD: shreg <= PI.
  - 100 ROTL: shreg <= {shreg[WIDTH-2:0], shreg[WIDTH-1]}.
  - 101 ROTR: shreg <= {shreg[0], shreg[WIDTH-1:1]}.
  - 110 CLR: shreg <= RESET_VAL.
  - 111: reserved; behaves as HOLD.
- clken=0: shreg and cnt hold.
- Outputs are combinational from shreg (zero added latency). A shift issued at edge N is visible on PO/SO after edge N.
- Shift counter: cnt is $clog2(WIDTH) bits wide. It increments on each clken-qualified shift operation (SHL, SHR, and ROTL/ROTR when rotate is compiled in).
  - When cnt==WIDTH-1 and a shift occurs, cnt wraps to 0 and word_done is registered high for exactly the next cycle.
  - LOAD or CLR sets cnt to 0 and does not pulse word_done.
  - HOLD, reserved and disabled cycles leave cnt unchanged.
- word_done is registered: it is 0 on any cycle not immediately following a wrapping shift, including cycles where clken=0.
- Back-to-back words: continuous shifting produces a pulse every WIDTH cycles with no gap cycle.
- Mixed directions: SHL and SHR share the same counter; direction changes do not reset it.
- Reset mid-word: cnt returns to 0, shreg to RESET_VAL, and a pending word_done is cancelled.
- Non-power-of-2 WIDTH: cnt wraps at WIDTH-1, not at 2^n-1.

Optional Feature:
Macro: USR_ROTATE_EN
- Defined: modes 100 and 101 rotate as specified and count as shifts.
- Undefined: modes 100 and 101 behave as HOLD. shreg and cnt are unchanged and no word_done is generated. No rotate muxing is synthesised.

Decomposition:
- Package shreg_pkg holds:
  - the mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_CLR;
  - typedef shreg_mode_t (logic [2:0]).
- One sub-module, shift_word_counter (params WIDTH; inputs clk, rst, inc, clr; output word_done). It owns cnt and the wrap/pulse logic.
- The top level computes inc and clr from clken and mode.

Test Plan:
- Reset: rst=1 for 2 cycles with WIDTH=8, RESET_VAL=8'hA5 -> PO=8'hA5, SO_L=1, SO_R=1, word_done=0. Then issue CLR after a load of 8'h00 -> PO returns to 8'hA5.
- SIPO, WIDTH=8: after reset, SHL 8 cycles with SI_L = 1,0,1,1,0,0,1,0 -> PO=8'hB2. word_done is high only in the cycle after the 8th shift. A 9th shift produces no pulse.
- PISO: LOAD PI=8'h81, then SHR 8 cycles with SI_R=0 -> SO_R sequence is 1,0,0,0,0,0,0,1 and word_done pulses once. clken dropped for 3 cycles mid-stream -> PO and cnt frozen, no pulse until the 8th shift completes.
- Counter clear: SHL 5 times, then LOAD 8'h3C, then SHL 8 times -> exactly one word_done, 8 cycles after the LOAD. SHL 5 times, then rst, then SHL 7 times -> no word_done.
- Rotate: with USR_ROTATE_EN, LOAD 8'h01, ROTL 3 times -> PO=8'h08, then ROTR 4 times -> PO=8'h80. Without the macro, the same stimulus keeps PO=8'h01 and no word_done. Mode 111 -> PO unchanged.
- WIDTH=5 (non-power-of-2) at default RESET_VAL: 10 consecutive SHL -> word_done pulses after shifts 5 and 10 only. WIDTH=32 (default): SI_L pattern 32'hDEADBEEF shifted MSB-first -> SO_L replays the pattern starting at cycle 33.
